// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit add/subtract: one full-adder cell, LSB first, with a
// start/done handshake and carry-out / signed-overflow flags.

module serial_addsub_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             ovf
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [CW-1:0]    cnt;
  logic             carry, carry_msb_in;
  logic             fa_s, fa_co;
  logic             last_step;

  serial_addsub_fa u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_step = (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Subtract is a + ~b + 1: the +1 rides in on the initial carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh         <= '0;
      b_sh         <= '0;
      res_sh       <= '0;
      cnt          <= '0;
      carry        <= 1'b0;
      carry_msb_in <= 1'b0;
      result       <= '0;
      c_out        <= 1'b0;
      ovf          <= 1'b0;
    end else if (state_q == IDLE && start) begin
      a_sh  <= a;
      b_sh  <= op_sub ? ~b : b;
      carry <= op_sub;
      cnt   <= '0;
    end else if (state_q == RUN) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      res_sh <= {fa_s, res_sh[WIDTH-1:1]};
      carry  <= fa_co;
      cnt    <= cnt + CW'(1);
      if (cnt == CW'(WIDTH-2)) carry_msb_in <= fa_co;
      // Final bit: publish the full result including this step's sum bit.
      if (last_step) begin
        result <= {fa_s, res_sh[WIDTH-1:1]};
        c_out  <= fa_co;
        ovf    <= carry_msb_in ^ fa_co;
      end
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub (WIDTH=8): latency, flags, ignored start,
// back-to-back accept and asynchronous reset mid-run.

module tb_serial_addsub;
  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             op_sub = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, c_out, ovf;
  logic [WIDTH-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  serial_addsub #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  // Drives one request, then watches edges 1..WIDTH+2 after the accept edge.
  task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic isub, output int lat, output int bcy,
                       output int ndone);
    @(negedge clk);
    a = ia; b = ib; op_sub = isub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom); op_sub = ~isub;
    lat = -1; bcy = 0; ndone = 0;
    if (busy) bcy++;
    for (int i = 1; i <= WIDTH + 2; i++) begin
      @(posedge clk); #1;
      if (busy) bcy++;
      if (done) begin
        ndone++;
        if (lat < 0) lat = i;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_cmp++;
    if ({busy, done, result, c_out, ovf} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b result=%h c_out=%b ovf=%b, want all 0",
               busy, done, result, c_out, ovf);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_add_ovf();
    int lat, bcy, nd;
    issue(8'h3C, 8'h5A, 1'b0, lat, bcy, nd);
    n_cmp++;
    if (lat !== WIDTH) begin n_bad++; $display("FAIL add_ovf_latency: got %0d want %0d", lat, WIDTH); end
    n_cmp++;
    if (bcy !== WIDTH) begin n_bad++; $display("FAIL add_ovf_busy_cycles: got %0d want %0d", bcy, WIDTH); end
    n_cmp++;
    if (nd !== 1) begin n_bad++; $display("FAIL add_ovf_done_pulses: got %0d want 1", nd); end
    n_cmp++;
    if ({result, c_out, ovf} !== {8'h96, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL add_ovf_result: got %h c=%b v=%b want 96 c=0 v=1", result, c_out, ovf);
    end
  endtask

  task automatic test_add_wrap();
    int lat, bcy, nd;
    issue(8'hFF, 8'h01, 1'b0, lat, bcy, nd);
    n_cmp++;
    if (lat !== WIDTH || nd !== 1) begin
      n_bad++; $display("FAIL add_wrap_done: got lat=%0d pulses=%0d want %0d 1", lat, nd, WIDTH);
    end
    n_cmp++;
    if ({result, c_out, ovf} !== {8'h00, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL add_wrap_result: got %h c=%b v=%b want 00 c=1 v=0", result, c_out, ovf);
    end
  endtask

  task automatic test_sub_borrow();
    int lat, bcy, nd;
    issue(8'h10, 8'h20, 1'b1, lat, bcy, nd);
    n_cmp++;
    if ({result, c_out, ovf} !== {8'hF0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL sub_borrow_result: got %h c=%b v=%b want F0 c=0 v=0", result, c_out, ovf);
    end
  endtask

  task automatic test_sub_ovf();
    int lat, bcy, nd;
    issue(8'h80, 8'h01, 1'b1, lat, bcy, nd);
    n_cmp++;
    if ({result, c_out, ovf} !== {8'h7F, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL sub_ovf_result: got %h c=%b v=%b want 7F c=1 v=1", result, c_out, ovf);
    end
  endtask

  task automatic test_start_while_busy();
    int lat, bcy, nd;
    @(negedge clk);
    a = 8'h01; b = 8'h01; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = -1; nd = 0;
    for (int i = 1; i <= WIDTH + 1; i++) begin
      if (i == 3) begin
        a = 8'hFF; b = 8'hFF; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        nd++;
        if (lat < 0) lat = i;
      end
    end
    n_cmp++;
    if (lat !== WIDTH || nd !== 1) begin
      n_bad++; $display("FAIL busy_start_done: got lat=%0d pulses=%0d want %0d 1", lat, nd, WIDTH);
    end
    n_cmp++;
    if (result !== 8'h02) begin
      n_bad++; $display("FAIL busy_start_result: got %h want 02", result);
    end
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++; $display("FAIL busy_start_idle: got busy=%b done=%b want 0 0", busy, done);
    end
    // Start asserted in the first IDLE cycle after done must be taken.
    issue(8'h05, 8'h03, 1'b0, lat, bcy, nd);
    n_cmp++;
    if (lat !== WIDTH || result !== 8'h08) begin
      n_bad++; $display("FAIL back_to_back: got lat=%0d result=%h want %0d 08", lat, result, WIDTH);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bcy, nd;
    @(negedge clk);
    a = 8'h55; b = 8'h11; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, result, c_out, ovf} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b result=%h c=%b v=%b want all 0",
               busy, done, result, c_out, ovf);
    end
    nd = 0;
    repeat (2) begin @(posedge clk); #1; if (done) nd++; end
    @(negedge clk) rst = 1'b0;
    repeat (WIDTH) begin @(posedge clk); #1; if (done || busy) nd++; end
    n_cmp++;
    if (nd !== 0) begin
      n_bad++; $display("FAIL reset_mid_no_done: got %0d busy/done cycles want 0", nd);
    end
    issue(8'h7F, 8'h01, 1'b0, lat, bcy, nd);
    n_cmp++;
    if (lat !== WIDTH || {result, c_out, ovf} !== {8'h80, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_mid_fresh: got lat=%0d %h c=%b v=%b want %0d 80 c=0 v=1",
               lat, result, c_out, ovf, WIDTH);
    end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_add_wrap();
    test_sub_borrow();
    test_sub_ovf();
    test_start_while_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
